// File: rtl/prog_mem.sv
// Loadable instruction memory: zero-fills after reset, accepts a program over a
// valid/ready stream, then serves registered single-cycle fetches to IF.
module prog_mem #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ld_start,
  input  logic              ld_clear,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              ifetch,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] idata,
  output logic              idata_valid,
  output logic              stall,
  output logic              addr_err,
  output logic              load_trunc
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_t;

  state_t                state, state_nx;
  logic [DEPTH_LOG2-1:0] clr_cnt, clr_cnt_nx;
  logic [DEPTH_LOG2-1:0] wr_ptr, wr_ptr_nx;
  logic                  load_trunc_nx;

  logic                  we;
  logic [DEPTH_LOG2-1:0] waddr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  ld_acc;
  logic                  fetch;
  logic                  oob;
  logic [DEPTH_LOG2-1:0] ridx;

  assign ld_ready = (state == ST_LOAD);
  assign stall    = (state != ST_RUN);
  assign ld_acc   = ld_valid && ld_ready;
  assign fetch    = ifetch && (state == ST_RUN);
  assign ridx     = iaddr[DEPTH_LOG2:1];
  // Any address bit above the word index means the fetch is outside the program.
  assign oob      = |(iaddr >> (DEPTH_LOG2 + 1));

  always_comb begin
    state_nx      = state;
    clr_cnt_nx    = clr_cnt;
    wr_ptr_nx     = wr_ptr;
    load_trunc_nx = load_trunc;
    we            = 1'b0;
    waddr         = '0;
    wdata         = '0;
    case (state)
      ST_CLEAR: begin
        we         = 1'b1;
        waddr      = clr_cnt;
        clr_cnt_nx = clr_cnt + 1'b1;
        if (clr_cnt == '1) begin
          state_nx  = ST_LOAD;
          wr_ptr_nx = '0;
        end
      end
      ST_LOAD: begin
        if (ld_acc) begin
          we    = 1'b1;
          waddr = wr_ptr;
          wdata = ld_data;
          if (ld_last) begin
            state_nx      = ST_RUN;
            load_trunc_nx = 1'b0;
            wr_ptr_nx     = wr_ptr + 1'b1;
          end else if (wr_ptr == '1) begin
            // Memory full without a terminator: stop here rather than wrap.
            state_nx      = ST_RUN;
            load_trunc_nx = 1'b1;
          end else begin
            wr_ptr_nx = wr_ptr + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (ld_start) begin
          if (ld_clear) begin
            state_nx   = ST_CLEAR;
            clr_cnt_nx = '0;
          end else begin
            state_nx  = ST_LOAD;
            wr_ptr_nx = '0;
          end
        end
      end
      default: state_nx = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_CLEAR;
      clr_cnt    <= '0;
      wr_ptr     <= '0;
      load_trunc <= 1'b0;
    end else begin
      state      <= state_nx;
      clr_cnt    <= clr_cnt_nx;
      wr_ptr     <= wr_ptr_nx;
      load_trunc <= load_trunc_nx;
    end
  end

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idata       <= '0;
      idata_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      idata_valid <= fetch;
      if (fetch) begin
        addr_err <= oob;
        idata    <= oob ? '0 : mem[ridx];
      end
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: clear timing, loading, fetch latency, address
// range errors, truncated loads, reload with/without clear and mid-load reset.
module tb_prog_mem;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ld_start, ld_clear, ld_valid, ld_last, ifetch;
  logic [15:0] ld_data, iaddr;
  logic        ld_ready, idata_valid, stall, addr_err, load_trunc;
  logic [15:0] idata;

  int checks   = 0;
  int failures = 0;

  prog_mem dut (
    .clock(clock), .reset_n(reset_n),
    .ld_start(ld_start), .ld_clear(ld_clear),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .ifetch(ifetch), .iaddr(iaddr), .idata(idata), .idata_valid(idata_valid),
    .stall(stall), .addr_err(addr_err), .load_trunc(load_trunc)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic fetch_req(input logic [15:0] a);
    ifetch = 1'b1; iaddr = a;
    tick();
    ifetch = 1'b0;
  endtask

  task automatic start_load(input logic clr);
    ld_start = 1'b1; ld_clear = clr;
    tick();
    ld_start = 1'b0; ld_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ld_start = 0; ld_clear = 0; ld_valid = 0; ld_data = 0;
    ld_last = 0; ifetch = 0; iaddr = 0;
    #12;
    checks++; if (stall !== 1'b1 || ld_ready !== 1'b0) begin failures++;
      $display("FAIL reset_hs stall=%b ld_ready=%b exp 1/0", stall, ld_ready); end
    checks++; if (idata !== 16'h0 || idata_valid !== 1'b0 || addr_err !== 1'b0 || load_trunc !== 1'b0) begin failures++;
      $display("FAIL reset_out idata=%h v=%b err=%b trunc=%b exp 0", idata, idata_valid, addr_err, load_trunc); end
    tick();
    reset_n = 1'b1;
    ifetch = 1'b1; iaddr = 16'h0;
    repeat (31) tick();
    checks++; if (ld_ready !== 1'b0 || stall !== 1'b1 || idata_valid !== 1'b0) begin failures++;
      $display("FAIL clear_31 ld_ready=%b stall=%b v=%b exp 0/1/0", ld_ready, stall, idata_valid); end
    tick();
    ifetch = 1'b0;
    checks++; if (ld_ready !== 1'b1 || stall !== 1'b1 || idata_valid !== 1'b0) begin failures++;
      $display("FAIL clear_32 ld_ready=%b stall=%b v=%b exp 1/1/0", ld_ready, stall, idata_valid); end
    push(16'h0000, 1'b1);
    checks++; if (stall !== 1'b0 || ld_ready !== 1'b0 || load_trunc !== 1'b0) begin failures++;
      $display("FAIL run_entry stall=%b ld_ready=%b trunc=%b exp 0/0/0", stall, ld_ready, load_trunc); end
    fetch_req(16'h0010);
    checks++; if (idata_valid !== 1'b1 || idata !== 16'h0000 || addr_err !== 1'b0) begin failures++;
      $display("FAIL fetch_10 v=%b idata=%h err=%b exp 1/0000/0", idata_valid, idata, addr_err); end
  endtask

  task automatic test_load();
    logic [15:0] prog [6];
    prog = '{16'h6103, 16'h0043, 16'h907D, 16'h7205, 16'h697F, 16'h407C};
    start_load(1'b0);
    checks++; if (ld_ready !== 1'b1 || stall !== 1'b1) begin failures++;
      $display("FAIL reload_enter ld_ready=%b stall=%b exp 1/1", ld_ready, stall); end
    for (int i = 0; i < 6; i++) begin
      push(prog[i], i == 5);
      if (i < 5) tick();
    end
    checks++; if (stall !== 1'b0 || load_trunc !== 1'b0) begin failures++;
      $display("FAIL load6_done stall=%b trunc=%b exp 0/0", stall, load_trunc); end
    ifetch = 1'b1; iaddr = 16'h0000;
    #2;
    checks++; if (idata_valid !== 1'b0) begin failures++;
      $display("FAIL latency_pre v=%b exp 0", idata_valid); end
    tick(); ifetch = 1'b0;
    checks++; if (idata_valid !== 1'b1 || idata !== 16'h6103) begin failures++;
      $display("FAIL fetch_0 v=%b idata=%h exp 1/6103", idata_valid, idata); end
    fetch_req(16'h0003);
    checks++; if (idata_valid !== 1'b1 || idata !== 16'h0043) begin failures++;
      $display("FAIL fetch_3 v=%b idata=%h exp 1/0043", idata_valid, idata); end
    fetch_req(16'h000A);
    checks++; if (idata_valid !== 1'b1 || idata !== 16'h407C) begin failures++;
      $display("FAIL fetch_A v=%b idata=%h exp 1/407C", idata_valid, idata); end
    tick();
    checks++; if (idata_valid !== 1'b0 || idata !== 16'h407C) begin failures++;
      $display("FAIL idle_hold v=%b idata=%h exp 0/407C", idata_valid, idata); end
  endtask

  task automatic test_addr_err();
    fetch_req(16'h0040);
    checks++; if (idata_valid !== 1'b1 || idata !== 16'h0000 || addr_err !== 1'b1) begin failures++;
      $display("FAIL oob_40 v=%b idata=%h err=%b exp 1/0000/1", idata_valid, idata, addr_err); end
    tick();
    checks++; if (addr_err !== 1'b1 || idata_valid !== 1'b0) begin failures++;
      $display("FAIL oob_hold err=%b v=%b exp 1/0", addr_err, idata_valid); end
    fetch_req(16'h0002);
    checks++; if (addr_err !== 1'b0 || idata !== 16'h0043) begin failures++;
      $display("FAIL after_oob err=%b idata=%h exp 0/0043", addr_err, idata); end
    fetch_req(16'h8002);
    checks++; if (addr_err !== 1'b1 || idata !== 16'h0000) begin failures++;
      $display("FAIL oob_8002 err=%b idata=%h exp 1/0000", addr_err, idata); end
    ld_valid = 1'b1; ld_data = 16'hFFFF; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    fetch_req(16'h0000);
    checks++; if (idata !== 16'h6103 || stall !== 1'b0) begin failures++;
      $display("FAIL run_ld_ignored idata=%h stall=%b exp 6103/0", idata, stall); end
  endtask

  task automatic test_start_fetch();
    ifetch = 1'b1; iaddr = 16'h0000; ld_start = 1'b1; ld_clear = 1'b0;
    tick();
    ifetch = 1'b0; ld_start = 1'b0;
    checks++; if (idata_valid !== 1'b1 || idata !== 16'h6103 || ld_ready !== 1'b1 || stall !== 1'b1) begin failures++;
      $display("FAIL start_fetch v=%b idata=%h rdy=%b stall=%b exp 1/6103/1/1", idata_valid, idata, ld_ready, stall); end
    start_load(1'b1);
    checks++; if (ld_ready !== 1'b1) begin failures++;
      $display("FAIL start_in_load ld_ready=%b exp 1", ld_ready); end
    push(16'hAAAA, 1'b1);
    fetch_req(16'h0000);
    checks++; if (idata !== 16'hAAAA) begin failures++;
      $display("FAIL reload_0 idata=%h exp AAAA", idata); end
    fetch_req(16'h0002);
    checks++; if (idata !== 16'h0043) begin failures++;
      $display("FAIL persist_2 idata=%h exp 0043", idata); end
    fetch_req(16'h000A);
    checks++; if (idata !== 16'h407C) begin failures++;
      $display("FAIL persist_A idata=%h exp 407C", idata); end
  endtask

  task automatic test_trunc();
    start_load(1'b0);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        checks++; if (ld_ready !== 1'b1) begin failures++;
          $display("FAIL trunc_31 ld_ready=%b exp 1", ld_ready); end
      end
      push(16'h1000 + 16'(i), 1'b0);
    end
    checks++; if (stall !== 1'b0 || ld_ready !== 1'b0 || load_trunc !== 1'b1) begin failures++;
      $display("FAIL trunc_done stall=%b rdy=%b trunc=%b exp 0/0/1", stall, ld_ready, load_trunc); end
    fetch_req(16'h003E);
    checks++; if (idata !== 16'h101F || addr_err !== 1'b0) begin failures++;
      $display("FAIL trunc_3E idata=%h err=%b exp 101F/0", idata, addr_err); end
    fetch_req(16'h0000);
    checks++; if (idata !== 16'h1000) begin failures++;
      $display("FAIL trunc_0 idata=%h exp 1000", idata); end
  endtask

  task automatic test_clear();
    start_load(1'b1);
    checks++; if (stall !== 1'b1 || ld_ready !== 1'b0) begin failures++;
      $display("FAIL clr_enter stall=%b rdy=%b exp 1/0", stall, ld_ready); end
    repeat (31) tick();
    checks++; if (ld_ready !== 1'b0) begin failures++;
      $display("FAIL clr_31 ld_ready=%b exp 0", ld_ready); end
    tick();
    checks++; if (ld_ready !== 1'b1) begin failures++;
      $display("FAIL clr_32 ld_ready=%b exp 1", ld_ready); end
    push(16'h5555, 1'b1);
    checks++; if (load_trunc !== 1'b0 || stall !== 1'b0) begin failures++;
      $display("FAIL clr_load trunc=%b stall=%b exp 0/0", load_trunc, stall); end
    fetch_req(16'h0002);
    checks++; if (idata !== 16'h0000) begin failures++;
      $display("FAIL clr_2 idata=%h exp 0000", idata); end
    fetch_req(16'h003E);
    checks++; if (idata !== 16'h0000) begin failures++;
      $display("FAIL clr_3E idata=%h exp 0000", idata); end
    fetch_req(16'h0000);
    checks++; if (idata !== 16'h5555) begin failures++;
      $display("FAIL clr_0 idata=%h exp 5555", idata); end
  endtask

  task automatic test_reset_midload();
    start_load(1'b0);
    push(16'hBEEF, 1'b0);
    push(16'hCAFE, 1'b0);
    push(16'hF00D, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (ld_ready !== 1'b0 || stall !== 1'b1 || idata_valid !== 1'b0 || idata !== 16'h0) begin failures++;
      $display("FAIL midreset rdy=%b stall=%b v=%b idata=%h exp 0/1/0/0000", ld_ready, stall, idata_valid, idata); end
    tick();
    reset_n = 1'b1;
    repeat (31) tick();
    checks++; if (ld_ready !== 1'b0) begin failures++;
      $display("FAIL rclr_31 ld_ready=%b exp 0", ld_ready); end
    tick();
    checks++; if (ld_ready !== 1'b1) begin failures++;
      $display("FAIL rclr_32 ld_ready=%b exp 1", ld_ready); end
    push(16'h1234, 1'b1);
    fetch_req(16'h0002);
    checks++; if (idata !== 16'h0000) begin failures++;
      $display("FAIL wiped_2 idata=%h exp 0000", idata); end
    fetch_req(16'h0004);
    checks++; if (idata !== 16'h0000) begin failures++;
      $display("FAIL wiped_4 idata=%h exp 0000", idata); end
    fetch_req(16'h0000);
    checks++; if (idata !== 16'h1234) begin failures++;
      $display("FAIL wiped_0 idata=%h exp 1234", idata); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_addr_err();
    test_start_fetch();
    test_trunc();
    test_clear();
    test_reset_midload();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
Name:
prog_mem

Overview:
Parametrised, loadable instruction memory for the 16-bit pipelined MIPS core. It replaces hard-coded program ROMs with a RAM that is zero-filled after reset and loaded at run time through a valid/ready stream. It then serves registered fetches to the IF stage. Fetches are stalled until a program is loaded.

Parameters:
DATA_W, 16, instruction width in bits
ADDR_W, 16, fetch byte-address width
DEPTH_LOG2, 5, log2 of word depth (DEPTH = 2**DEPTH_LOG2 = 32 words)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
ld_start  in  1  pulse: re-enter LOAD from RUN
ld_clear  in  1  sampled with ld_start: zero-fill memory before LOAD
ld_valid  in  1  load word present
ld_data  in  DATA_W  load word
ld_last  in  1  marks final load word
ld_ready  out  1  memory accepts a load word this cycle
ifetch  in  1  fetch request
iaddr  in  ADDR_W  fetch byte address
idata  out  DATA_W  fetched instruction (registered)
idata_valid  out  1  idata updated this cycle
stall  out  1  fetch not serviceable (CLEAR or LOAD)
addr_err  out  1  last fetch address was out of range
load_trunc  out  1  sticky: last load hit DEPTH without ld_last

Behaviour:
- Reset (async, reset_n=0) sets state=CLEAR, clr_cnt=0, wr_ptr=0, idata=0, idata_valid=0, addr_err=0, load_trunc=0, ld_ready=0, stall=1. Memory contents are not reset directly.
- States are CLEAR, LOAD and RUN. Outputs are decoded from registered state.
- CLEAR:
  - Each cycle writes 0 to mem[clr_cnt], then clr_cnt++.
  - After writing DEPTH-1, moves to LOAD with wr_ptr=0. This takes exactly DEPTH cycles.
  - stall=1, ld_ready=0.
- LOAD:
  - ld_ready=1, stall=1.
  - On ld_valid&ld_ready: mem[wr_ptr]=ld_data, wr_ptr++.
  - If the accepted word has ld_last=1, next state is RUN and load_trunc is cleared.
  - If the accepted word is at wr_ptr=DEPTH-1 with ld_last=0, next state is RUN and load_trunc is set to 1.
  - Words are never written past DEPTH-1. wr_ptr does not wrap within a load.
- RUN:
  - stall=0, ld_ready=0.
  - ifetch at cycle t yields idata and idata_valid=1 at t+1. Latency is 1.
  - Word index = iaddr[DEPTH_LOG2:1]. iaddr[0] is ignored.
  - If any bit of iaddr[ADDR_W-1:DEPTH_LOG2+1] is 1: idata=0 (NOP) and addr_err=1 at t+1. Otherwise addr_err=0 at t+1.
  - With no ifetch: idata_valid=0, and idata and addr_err hold their values.
- ld_start in RUN:
  - With ld_clear=0: next state LOAD, wr_ptr=0. Existing words beyond the new load persist.
  - With ld_clear=1: next state CLEAR, clr_cnt=0.
  - ld_start is ignored in CLEAR and LOAD.
- ld_start and ifetch in the same RUN cycle: the fetch is still served (valid at t+1), and the state changes as above.
- ifetch while stall=1 is ignored: idata_valid=0 and no queuing.
- ld_valid outside LOAD is ignored.
- reset_n asserted mid-CLEAR or mid-LOAD returns all outputs immediately to their reset values. The partial program is discarded by the following CLEAR.
- Memory is a single write port and a single synchronous read port, inferable as distributed or block RAM. There is at most one write per cycle.

Test Plan:
1. Reset, hold reset_n=1 -> stall=1 and ld_ready=0 for exactly 32 cycles, then ld_ready=1. Load a single word 0x0000 with ld_last=1 -> RUN. Fetch iaddr=0x0010 -> idata=0x0000, idata_valid=1 one cycle later.
2. Load 0x6103, 0x0043, 0x907D, 0x7205, 0x697F, 0x407C (ld_last on 6th) with ld_valid gaps -> RUN, load_trunc=0.
   - Fetch iaddr 0x0000 -> 0x6103.
   - Fetch iaddr 0x0003 -> 0x0043 (bit0 ignored).
   - Fetch iaddr 0x000A -> 0x407C.
   - Each result appears exactly 1 cycle after ifetch.
3. RUN, fetch iaddr=0x0040 -> idata=0x0000, addr_err=1. Next fetch 0x0002 -> addr_err=0, idata=0x0043.
4. Load 32 words 0x1000..0x101F with no ld_last -> RUN after the 32nd accept, load_trunc=1. Fetch 0x003E -> 0x101F.
5. RUN, ld_start=1, ld_clear=0 with ifetch iaddr=0 same cycle -> idata=0x6103 valid next cycle, state LOAD. Reload 1 word 0xAAAA with last -> addr 0 = 0xAAAA, addr 2 still 0x0043.
   - Then ld_start with ld_clear=1 -> 32 stall cycles; after a 1-word load, addr 2 reads 0x0000.
6. Assert reset_n=0 after 3 load words -> ld_ready=0, stall=1, idata_valid=0 immediately. After release, 32-cycle CLEAR is repeated and old words read 0.
